stage_mem: RTL

Memory-access pipeline stage of the five-stage in-order CPU, between EX and WB. Holds the EX→MEM pipeline registers and its own valid bit, runs the valid/allowin handshake, and decodes load width and sign plus the byte-lane mask from the address low bits. Also completes the second half of a two-cycle 33×33 multiplier, so every multiply stays in MEM for at least two cycles. Its outputs feed the WB stage directly.

---
 rtl/stage_mem.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
// MEM stage of the five-stage in-order pipeline: EX->MEM pipeline registers,
// valid/allowin handshake, load-width/byte-lane decode and the second half of the 33x33 multiply.
module stage_mem (
  input  logic        clk,
  input  logic        reset,

  input  logic        valid_EX,
  input  logic        allowin_WB,
  output logic        allowin_MEM,
  output logic        pipe_tonext_valid_MEM,
  output logic        pipe_valid_MEM,

  input  logic [31:0] pc_EX,
  input  logic [31:0] alu_result_EX,
  input  logic [4:0]  dest_EX,
  input  logic        gr_we_EX,
  input  logic        res_from_mem_EX,
  input  logic [2:0]  ld_op_EX,
  input  logic        ld_signed_EX,
  input  logic        mul_inst_EX,
  input  logic [2:0]  mul_op_EX,
  input  logic [31:0] mul_src1_EX,
  input  logic [31:0] mul_src2_EX,

  output logic [31:0] pc_MEM,
  output logic [31:0] alu_result_MEM,
  output logic [4:0]  dest_MEM,
  output logic        gr_we_MEM,
  output logic        res_from_mem_MEM,
  output logic        mul_inst_MEM,
  output logic [2:0]  mul_op_MEM,

  output logic [3:0]  mask_dataram,
  output logic        byte_we,
  output logic        half_we,
  output logic        word_we,
  output logic        signed_we,
  output logic [63:0] mul_result
);

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DWIDTH = 64;
  localparam int unsigned RADDR  = 5;
  localparam int unsigned AWIDTH = WIDTH + 1;
  localparam int unsigned PWIDTH = 50;

  typedef enum logic {
    MUL_FIRST = 1'b0,
    MUL_DONE  = 1'b1
  } mul_st_e;

  logic              pipe_valid_q, pipe_valid_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  alu_result_q, alu_result_d;
  logic [RADDR-1:0]  dest_q, dest_d;
  logic              gr_we_q, gr_we_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic              ld_signed_q, ld_signed_d;
  logic              mul_inst_q, mul_inst_d;
  logic [2:0]        mul_op_q, mul_op_d;
  logic [WIDTH-1:0]  mul_src1_q, mul_src1_d;
  logic [WIDTH-1:0]  mul_src2_q, mul_src2_d;

  mul_st_e                  mul_st_q, mul_st_d;
  logic signed [PWIDTH-1:0] p_q, p_d;

  logic                     ready_go;
  logic                     load_en;
  logic signed [AWIDTH-1:0] a_ext;
  logic signed [AWIDTH-1:0] b_ext;
  logic signed [PWIDTH-1:0] p_lo;
  logic signed [PWIDTH-1:0] p_hi;
  logic [DWIDTH-1:0]        mul_sum;
  logic [2:0]               ld_we;
  logic [3:0]               mask;

  // Handshake: a multiply is not ready until its second cycle.
  always_comb begin
    ready_go              = !mul_inst_q || (mul_st_q == MUL_DONE);
    allowin_MEM           = !pipe_valid_q || (ready_go && allowin_WB);
    pipe_tonext_valid_MEM = pipe_valid_q && ready_go && allowin_WB;
    load_en               = allowin_MEM && valid_EX;
  end

  // Next-state for the valid bit and the EX->MEM data registers.
  always_comb begin
    pipe_valid_d   = pipe_valid_q;
    pc_d           = pc_q;
    alu_result_d   = alu_result_q;
    dest_d         = dest_q;
    gr_we_d        = gr_we_q;
    res_from_mem_d = res_from_mem_q;
    ld_op_d        = ld_op_q;
    ld_signed_d    = ld_signed_q;
    mul_inst_d     = mul_inst_q;
    mul_op_d       = mul_op_q;
    mul_src1_d     = mul_src1_q;
    mul_src2_d     = mul_src2_q;
    if (allowin_MEM) begin
      pipe_valid_d = valid_EX;
    end
    if (load_en) begin
      pc_d           = pc_EX;
      alu_result_d   = alu_result_EX;
      dest_d         = dest_EX;
      gr_we_d        = gr_we_EX;
      res_from_mem_d = res_from_mem_EX;
      ld_op_d        = ld_op_EX;
      ld_signed_d    = ld_signed_EX;
      mul_inst_d     = mul_inst_EX;
      mul_op_d       = mul_op_EX;
      mul_src1_d     = mul_src1_EX;
      mul_src2_d     = mul_src2_EX;
    end
  end

  // Split multiply: low 16 bits of B first, signed upper 17 bits of B combined in DONE.
  always_comb begin
    a_ext   = $signed({mul_op_q[1] & mul_src1_q[WIDTH-1], mul_src1_q});
    b_ext   = $signed({mul_op_q[1] & mul_src2_q[WIDTH-1], mul_src2_q});
    p_lo    = PWIDTH'(a_ext) * PWIDTH'($signed({1'b0, b_ext[15:0]}));
    p_hi    = PWIDTH'(a_ext) * PWIDTH'($signed(b_ext[AWIDTH-1:16]));
    mul_sum = {{(DWIDTH-PWIDTH){p_q[PWIDTH-1]}}, p_q} + {p_hi[DWIDTH-17:0], 16'h0000};
  end

  // Multiplier state machine: next-state and partial-product register.
  always_comb begin
    mul_st_d = mul_st_q;
    p_d      = p_q;
    case (mul_st_q)
      MUL_FIRST: begin
        if (pipe_valid_q && mul_inst_q) begin
          p_d      = p_lo;
          mul_st_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (pipe_tonext_valid_MEM) begin
          mul_st_d = MUL_FIRST;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q   <= 1'b0;
      pc_q           <= '0;
      alu_result_q   <= '0;
      dest_q         <= '0;
      gr_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= '0;
      ld_signed_q    <= 1'b0;
      mul_inst_q     <= 1'b0;
      mul_op_q       <= '0;
      mul_src1_q     <= '0;
      mul_src2_q     <= '0;
      mul_st_q       <= MUL_FIRST;
      p_q            <= '0;
    end else begin
      pipe_valid_q   <= pipe_valid_d;
      pc_q           <= pc_d;
      alu_result_q   <= alu_result_d;
      dest_q         <= dest_d;
      gr_we_q        <= gr_we_d;
      res_from_mem_q <= res_from_mem_d;
      ld_op_q        <= ld_op_d;
      ld_signed_q    <= ld_signed_d;
      mul_inst_q     <= mul_inst_d;
      mul_op_q       <= mul_op_d;
      mul_src1_q     <= mul_src1_d;
      mul_src2_q     <= mul_src2_d;
      mul_st_q       <= mul_st_d;
      p_q            <= p_d;
    end
  end

  // Load width decode and byte-lane mask; misalignment is trapped upstream.
  always_comb begin
    ld_we = ld_op_q & {3{res_from_mem_q}};
    mask  = 4'b0000;
    if (ld_we[0]) begin
      mask = 4'b0001 << alu_result_q[1:0];
    end else if (ld_we[1]) begin
      mask = alu_result_q[1] ? 4'b1100 : 4'b0011;
    end else if (ld_we[2]) begin
      mask = 4'b1111;
    end
  end

  assign pipe_valid_MEM   = pipe_valid_q;
  assign pc_MEM           = pc_q;
  assign alu_result_MEM   = alu_result_q;
  assign dest_MEM         = dest_q;
  assign gr_we_MEM        = gr_we_q;
  assign res_from_mem_MEM = res_from_mem_q;
  assign mul_inst_MEM     = mul_inst_q;
  assign mul_op_MEM       = mul_op_q;
  assign mask_dataram     = mask;
  assign byte_we          = ld_we[0];
  assign half_we          = ld_we[1];
  assign word_we          = ld_we[2];
  assign signed_we        = ld_signed_q;
  assign mul_result       = mul_sum;

endmodule
